// File: rtl/aes_block_serializer.sv
// aes_block_serializer: buffers whole AES blocks plus round-0 key and streams them byte-serially
//
// Ports:
//   i_clk, i_rst    clock; asynchronous active-high reset
//   i_blk_valid     host presents a block
//   o_blk_ready     FIFO has room (registered count only, no bypass)
//   i_blk_data      block data, byte 0 in the MSBs
//   i_blk_key       round-0 key, same byte order as i_blk_data
//   i_enc_dec       block mode: 1 = encrypt, 0 = decrypt
//   i_core_ready    core consumes the presented byte this cycle
//   o_byte_valid    o_data_byte / o_key_byte are valid
//   o_data_byte     current data byte
//   o_key_byte      current key byte
//   o_byte_idx      index of current byte within the block
//   o_first         current byte is index 0
//   o_last          current byte is index BLOCK_BYTES-1
//   o_enc_dec       mode of the block currently streaming
//   o_busy          FIFO non-empty or a block is streaming
//
// Optional: define AES_SER_STATS_EN to add
//   o_blk_sent_cnt  blocks whose last byte transferred (16-bit, wraps)
//   o_stall_cnt     cycles with o_byte_valid && !i_core_ready (16-bit, wraps)
module aes_block_serializer #(
    parameter int WIDTH       = 8,
    parameter int BLOCK_BYTES = 16,
    parameter int DEPTH       = 2
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_blk_valid,
    output logic                           o_blk_ready,
    input  logic [WIDTH*BLOCK_BYTES-1:0]   i_blk_data,
    input  logic [WIDTH*BLOCK_BYTES-1:0]   i_blk_key,
    input  logic                           i_enc_dec,
    input  logic                           i_core_ready,
    output logic                           o_byte_valid,
    output logic [WIDTH-1:0]               o_data_byte,
    output logic [WIDTH-1:0]               o_key_byte,
    output logic [$clog2(BLOCK_BYTES)-1:0] o_byte_idx,
    output logic                           o_first,
    output logic                           o_last,
    output logic                           o_enc_dec,
    output logic                           o_busy
`ifdef AES_SER_STATS_EN
    ,
    output logic [15:0]                    o_blk_sent_cnt,
    output logic [15:0]                    o_stall_cnt
`endif
);

    localparam int BW = WIDTH * BLOCK_BYTES;
    localparam int IW = $clog2(BLOCK_BYTES);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_BYTES - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]    data_mem_q [DEPTH];
    logic [BW-1:0]    data_mem_d [DEPTH];
    logic [BW-1:0]    key_mem_q [DEPTH];
    logic [BW-1:0]    key_mem_d [DEPTH];
    logic [DEPTH-1:0] mode_mem_q, mode_mem_d;
    logic [BW-1:0]    data_sr_q, data_sr_d;
    logic [BW-1:0]    key_sr_q, key_sr_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             push, pop, xfer, last;

    always_comb begin
        last = idx_q == LAST_IDX;
        xfer = (state_q == SEND) && i_core_ready;
        push = i_blk_valid && o_blk_ready;
        // A finishing transfer pops the next block in the same cycle so blocks stream without a bubble.
        pop  = (cnt_q != '0) && ((state_q == IDLE) || (xfer && last));
        data_mem_d = data_mem_q;
        key_mem_d  = key_mem_q;
        mode_mem_d = mode_mem_q;
        if (push) begin
            data_mem_d[wr_ptr_q] = i_blk_data;
            key_mem_d[wr_ptr_q]  = i_blk_key;
            mode_mem_d[wr_ptr_q] = i_enc_dec;
        end
        wr_ptr_d = push ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1)) : rd_ptr_q;
        cnt_d = cnt_q;
        if (push && !pop)
            cnt_d = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_d = cnt_q - CW'(1);
        // The final shift of a block empties the registers and wraps idx to 0, so IDLE presents zeros.
        data_sr_d = pop ? data_mem_q[rd_ptr_q] : xfer ? data_sr_q << WIDTH : data_sr_q;
        key_sr_d  = pop ? key_mem_q[rd_ptr_q] : xfer ? key_sr_q << WIDTH : key_sr_q;
        idx_d     = pop ? '0 : xfer ? idx_q + IW'(1) : idx_q;
        mode_d    = pop ? mode_mem_q[rd_ptr_q] : mode_q;
        state_d   = pop ? SEND : (xfer && last) ? IDLE : state_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_mem_q <= '{default: '0};
            key_mem_q  <= '{default: '0};
            mode_mem_q <= '0;
            data_sr_q  <= '0;
            key_sr_q   <= '0;
            idx_q      <= '0;
            mode_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_mem_q <= data_mem_d;
            key_mem_q  <= key_mem_d;
            mode_mem_q <= mode_mem_d;
            data_sr_q  <= data_sr_d;
            key_sr_q   <= key_sr_d;
            idx_q      <= idx_d;
            mode_q     <= mode_d;
        end
    end

    assign o_blk_ready  = cnt_q < FULL_CNT;
    assign o_byte_valid = state_q == SEND;
    assign o_data_byte  = data_sr_q[BW-1 -: WIDTH];
    assign o_key_byte   = key_sr_q[BW-1 -: WIDTH];
    assign o_byte_idx   = idx_q;
    assign o_first      = (state_q == SEND) && (idx_q == '0);
    assign o_last       = (state_q == SEND) && last;
    assign o_enc_dec    = mode_q;
    assign o_busy       = (state_q != IDLE) || (cnt_q != '0);

`ifdef AES_SER_STATS_EN
    logic [15:0] sent_q, sent_d;
    logic [15:0] stall_q, stall_d;

    always_comb begin
        sent_d  = sent_q + {15'd0, xfer && last};
        stall_d = stall_q + {15'd0, o_byte_valid && !i_core_ready};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sent_q  <= '0;
            stall_q <= '0;
        end else begin
            sent_q  <= sent_d;
            stall_q <= stall_d;
        end
    end

    assign o_blk_sent_cnt = sent_q;
    assign o_stall_cnt    = stall_q;
`endif

endmodule

// File: tb/tb_aes_block_serializer.sv
// tb_aes_block_serializer: scoreboard bench for aes_block_serializer with a block-to-byte reference model
module tb_aes_block_serializer;

    localparam int BW = 128;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_blk_valid;
    logic         o_blk_ready;
    logic [127:0] i_blk_data;
    logic [127:0] i_blk_key;
    logic         i_enc_dec;
    logic         i_core_ready;
    logic         o_byte_valid;
    logic [7:0]   o_data_byte;
    logic [7:0]   o_key_byte;
    logic [3:0]   o_byte_idx;
    logic         o_first;
    logic         o_last;
    logic         o_enc_dec;
    logic         o_busy;
`ifdef AES_SER_STATS_EN
    logic [15:0]  o_blk_sent_cnt;
    logic [15:0]  o_stall_cnt;
`endif

    aes_block_serializer #(.WIDTH(8), .BLOCK_BYTES(16), .DEPTH(2)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_blk_valid  (i_blk_valid),
        .o_blk_ready  (o_blk_ready),
        .i_blk_data   (i_blk_data),
        .i_blk_key    (i_blk_key),
        .i_enc_dec    (i_enc_dec),
        .i_core_ready (i_core_ready),
        .o_byte_valid (o_byte_valid),
        .o_data_byte  (o_data_byte),
        .o_key_byte   (o_key_byte),
        .o_byte_idx   (o_byte_idx),
        .o_first      (o_first),
        .o_last       (o_last),
        .o_enc_dec    (o_enc_dec),
        .o_busy       (o_busy)
`ifdef AES_SER_STATS_EN
        ,
        .o_blk_sent_cnt (o_blk_sent_cnt),
        .o_stall_cnt    (o_stall_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] d;
        logic [7:0] k;
        logic [3:0] idx;
        logic       first;
        logic       last;
        logic       mode;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int core_mode = 0;
    int valid_cnt = 0;
    int run_len = 0;
    int max_run = 0;
    int sent_model = 0;
    int stall_model = 0;
    logic         held = 1'b0;
    logic [127:0] saved;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] out_vec();
        return 128'({o_byte_valid, o_data_byte, o_key_byte, o_byte_idx, o_first, o_last, o_enc_dec});
    endfunction

    // Reference model: a block becomes 16 (data byte, key byte, idx, first, last, mode) tuples in order.
    task automatic model_block(input logic [127:0] d, input logic [127:0] k, input logic m);
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e.d     = d[BW-1-8*i -: 8];
            e.k     = k[BW-1-8*i -: 8];
            e.idx   = 4'(i);
            e.first = (i == 0);
            e.last  = (i == 15);
            e.mode  = m;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_blk(input logic [127:0] d, input logic [127:0] k, input logic m);
        i_blk_data  = d;
        i_blk_key   = k;
        i_enc_dec   = m;
        i_blk_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge i_clk);
            if (o_blk_ready) break;
            if (t >= 500) begin
                chk("push_timeout", 128'(o_blk_ready), 128'(1));
                i_blk_valid = 1'b0;
                return;
            end
        end
        @(posedge i_clk);
        #1;
        i_blk_valid = 1'b0;
        i_blk_data  = {$urandom, $urandom, $urandom, $urandom};
        i_blk_key   = {$urandom, $urandom, $urandom, $urandom};
        i_enc_dec   = 1'($urandom);
        model_block(d, k, m);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 2000; t++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_busy) return;
        end
        chk("idle_timeout", 128'(exp_q.size()), 128'(0));
    endtask

    always @(posedge i_clk) begin
        #1;
        if (core_mode == 1)
            i_core_ready = ~i_core_ready;
        else if (core_mode == 2)
            i_core_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pops the scoreboard on every transfer and checks hold-stability across stalls.
    always @(negedge i_clk) begin
        if (i_rst) begin
            held        = 1'b0;
            run_len     = 0;
            sent_model  = 0;
            stall_model = 0;
        end else begin
            exp_t e;
            chk("busy", 128'(o_busy), 128'(exp_q.size() != 0));
            if (held)
                chk("stall_stable", out_vec(), saved);
            if (o_byte_valid) begin
                valid_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (o_byte_valid && i_core_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", out_vec(), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", out_vec(), 128'({1'b1, e.d, e.k, e.idx, e.first, e.last, e.mode}));
                    if (e.last) sent_model++;
                end
            end
            held = o_byte_valid && !i_core_ready;
            if (held) begin
                stall_model++;
                saved = out_vec();
            end
        end
    end

    initial begin
        i_rst        = 1'b0;
        i_blk_valid  = 1'b0;
        i_blk_data   = '0;
        i_blk_key    = '0;
        i_enc_dec    = 1'b0;
        i_core_ready = 1'b1;
        #2 i_rst = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_outputs", 128'({out_vec(), o_busy}), 128'(0));
        chk("rst_ready", 128'(o_blk_ready), 128'(1));
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        @(posedge i_clk);
        #1;

`ifdef AES_SER_STATS_EN
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        i_core_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        i_core_ready = 1'b1;
        wait_idle();
        chk("stats_sent", 128'(o_blk_sent_cnt), 128'(3));
        chk("stats_stall", 128'(o_stall_cnt), 128'(5));
        chk("stats_model", 128'({o_blk_sent_cnt, o_stall_cnt}), 128'({16'(sent_model), 16'(stall_model)}));
        @(posedge i_clk);
        #1;
`endif

        // Single block with first-byte latency.
        valid_cnt = 0;
        push_blk(128'h00112233_44556677_8899AABB_CCDDEEFF, 128'h00010203_04050607_08090A0B_0C0D0E0F, 1'b1);
        @(negedge i_clk);
        chk("latency_pop_edge", 128'(o_byte_valid), 128'(0));
        @(negedge i_clk);
        chk("latency_first", 128'({o_byte_valid, o_first, o_data_byte, o_key_byte}), 128'({1'b1, 1'b1, 8'h00, 8'h00}));
        wait_idle();
        chk("single_cycles", 128'(valid_cnt), 128'(16));

        // Back-to-back: A encrypt then B decrypt, no bubble.
        @(posedge i_clk);
        #1;
        max_run = 0;
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        wait_idle();
        chk("b2b_run", 128'(max_run), 128'(32));

        // Full FIFO while the core stalls.
        @(posedge i_clk);
        #1;
        i_core_ready = 1'b0;
        for (int b = 0; b < 3; b++)
            push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, b[0]);
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            chk("full_ready", 128'(o_blk_ready), 128'(0));
        end
        @(posedge i_clk);
        #1;
        i_core_ready = 1'b1;
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        wait_idle();

        // Alternating core ready: stall first, then 16 transfers interleaved with stalls.
        @(posedge i_clk);
        #1;
        i_core_ready = 1'b0;
        valid_cnt = 0;
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        #1;
        i_core_ready = 1'b1;
        core_mode = 1;
        wait_idle();
        core_mode = 0;
        i_core_ready = 1'b1;
        chk("toggle_cycles", 128'(valid_cnt), 128'(32));

        // Reset mid-block with one block queued.
        @(posedge i_clk);
        #1;
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        for (int t = 0; ; t++) begin
            @(negedge i_clk);
            if (o_byte_valid && o_byte_idx == 4'd7) break;
            if (t >= 100) begin
                chk("idx7_timeout", 128'(o_byte_idx), 128'(7));
                break;
            end
        end
        #2 i_rst = 1'b1;
        #1;
        chk("midrst_outputs", 128'({out_vec(), o_busy}), 128'(0));
        chk("midrst_ready", 128'(o_blk_ready), 128'(1));
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        #2 i_rst = 1'b0;
        #1;
        chk("postrst_ready", 128'(o_blk_ready), 128'(1));
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            chk("postrst_quiet", 128'({o_byte_valid, o_busy}), 128'(0));
        end

        // Randomized blocks, gaps and core back-pressure.
        @(posedge i_clk);
        #1;
        core_mode = 2;
        for (int b = 0; b < 10; b++) begin
            repeat ($urandom_range(0, 3)) @(posedge i_clk);
            #1;
            push_blk({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
        end
        wait_idle();
        core_mode = 0;
        i_core_ready = 1'b1;
        chk("final_queue", 128'(exp_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
